sample_fifo: RTL and testbench

Byte FIFO sitting directly upstream of the master serial interface: the capture/packing logic writes sample bytes in, and the master interface pops them with `fifoRd`, flushes with `fifoClr`, and gates transfers on the occupancy count `wrcnt`. Single clock domain, registered read data, sticky overflow/underflow flags, and a block-ready indication once a full transfer block is buffered.

---
 rtl/sample_fifo.sv | 56 +++++
 tb/tb_sample_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// sample_fifo: byte FIFO feeding the master serial interface, with occupancy
// count, block-ready indication and sticky overflow/underflow flags.
module sample_fifo #(
  parameter int DEPTH     = 512,
  parameter int BLOCKSIZE = 256
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  input  logic       fifoRd,
  input  logic       fifoClr,
  output logic [7:0] rdata,
  output logic [9:0] wrcnt,
  output logic       full,
  output logic       empty,
  output logic       blk_rdy,
  output logic       overflow,
  output logic       underflow
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic              pop, push;
  logic [9:0]        cnt_n;
  // a pop frees the slot a same-cycle write needs when full
  always_comb begin
    pop   = fifoRd && !empty;
    push  = wr_en && (!full || pop);
    cnt_n = fifoClr ? '0 : (push && !pop) ? wrcnt + 10'd1 : (pop && !push) ? wrcnt - 10'd1 : wrcnt;
  end
  always_ff @(posedge clk)
    if (push && !fifoClr) mem[wptr] <= wdata;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      wrcnt     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      blk_rdy   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= fifoClr ? '0 : push ? wptr + ADDR_W'(1) : wptr;
      rptr      <= fifoClr ? '0 : pop ? rptr + ADDR_W'(1) : rptr;
      rdata     <= (pop && !fifoClr) ? mem[rptr] : rdata;
      wrcnt     <= cnt_n;
      full      <= cnt_n == 10'(DEPTH);
      empty     <= cnt_n == '0;
      blk_rdy   <= cnt_n >= 10'(BLOCKSIZE);
      overflow  <= !fifoClr && (overflow || (wr_en && !push));
      underflow <= !fifoClr && (underflow || (fifoRd && !pop));
    end
endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: table vectors plus hand sequences, checked against a queue
// reference model of an 8-deep FIFO with block size 4.
module tb_sample_fifo;
  localparam int DEPTH = 8;
  localparam int BLK   = 4;
  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       wr_en = 1'b0, fifoRd = 1'b0, fifoClr = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic [9:0] wrcnt;
  logic       full, empty, blk_rdy, overflow, underflow;
  int         tests = 0, fails = 0;
  logic [7:0] q[$];
  logic [7:0] exp_rd = '0;
  logic       m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    logic       wr, rd;
    logic [7:0] d;
    logic [9:0] cnt;
    logic       ovf, unf;
  } vec_t;
  vec_t vecs[$];

  sample_fifo #(.DEPTH(DEPTH), .BLOCKSIZE(BLK)) dut (
    .clk(clk), .arst(arst), .wr_en(wr_en), .wdata(wdata), .fifoRd(fifoRd),
    .fifoClr(fifoClr), .rdata(rdata), .wrcnt(wrcnt), .full(full), .empty(empty),
    .blk_rdy(blk_rdy), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, " wrcnt"}, 32'(wrcnt), 32'(q.size()));
    chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, " blk_rdy"}, 32'(blk_rdy), 32'(q.size() >= BLK));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // drive one cycle, advance the reference model, compare after the edge
  task automatic apply(input string tag, input logic wr, input logic rd, input logic clr, input logic [7:0] d);
    logic pop_ok, push_ok;
    wr_en = wr; fifoRd = rd; fifoClr = clr; wdata = d;
    pop_ok  = rd && q.size() != 0;
    push_ok = wr && (q.size() != DEPTH || pop_ok);
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (pop_ok) exp_rd = q.pop_front();
      if (push_ok) q.push_back(d);
      m_ovf = m_ovf || (wr && !push_ok);
      m_unf = m_unf || (rd && !pop_ok);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; fifoRd = 1'b0; fifoClr = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    chk_all("post-reset");
    apply("first write", 1, 0, 0, 8'hA5);
    chk("first write wrcnt=1", 32'(wrcnt), 32'd1);
    chk("first write empty=0", 32'(empty), 32'd0);
    apply("pop A5", 0, 1, 0, 8'h00);
    chk("pop A5 rdata", 32'(rdata), 32'hA5);
    apply("burst w", 1, 0, 0, 8'h3C);
    apply("burst w", 1, 0, 0, 8'h4D);
    apply("burst w", 1, 0, 0, 8'h5E);
    #2;
    wr_en = 1'($urandom_range(0, 1)); fifoRd = 1'($urandom_range(0, 1));
    fifoClr = 1'($urandom_range(0, 1)); wdata = 8'($urandom);
    arst = 1'b1;
    #1;
    q.delete(); exp_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
    chk_all("async reset");
    @(posedge clk);
    #1;
    chk_all("held reset");
    wr_en = 1'b0; fifoRd = 1'b0; fifoClr = 1'b0; arst = 1'b0;

    apply("order w", 1, 0, 0, 8'h11);
    apply("order w", 1, 0, 0, 8'h22);
    apply("order w", 1, 0, 0, 8'h33);
    chk("order wrcnt=3", 32'(wrcnt), 32'd3);
    apply("order r", 0, 1, 0, 8'h00);
    chk("order rdata 11", 32'(rdata), 32'h11);
    apply("order r", 0, 1, 0, 8'h00);
    chk("order rdata 22", 32'(rdata), 32'h22);
    apply("order r", 0, 1, 0, 8'h00);
    chk("order rdata 33", 32'(rdata), 32'h33);
    chk("order empty", 32'(empty), 32'd1);

    // fill past full, drain, then pop and write+pop on empty
    for (int i = 1; i <= 9; i++)
      vecs.push_back('{wr: 1'b1, rd: 1'b0, d: 8'(i), cnt: 10'(i > 8 ? 8 : i), ovf: i == 9, unf: 1'b0});
    for (int i = 7; i >= 0; i--)
      vecs.push_back('{wr: 1'b0, rd: 1'b1, d: 8'h00, cnt: 10'(i), ovf: 1'b1, unf: 1'b0});
    vecs.push_back('{wr: 1'b0, rd: 1'b1, d: 8'h00, cnt: 10'd0, ovf: 1'b1, unf: 1'b1});
    vecs.push_back('{wr: 1'b1, rd: 1'b1, d: 8'h77, cnt: 10'd1, ovf: 1'b1, unf: 1'b1});
    vecs.push_back('{wr: 1'b0, rd: 1'b1, d: 8'h00, cnt: 10'd0, ovf: 1'b1, unf: 1'b1});
    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].d);
      chk($sformatf("vec%0d cnt", i), 32'(wrcnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d unf", i), 32'(underflow), 32'(vecs[i].unf));
      if (i == 3) chk("blk_rdy on 4th write", 32'(blk_rdy), 32'd1);
      if (i == 2) chk("blk_rdy low on 3rd write", 32'(blk_rdy), 32'd0);
      if (i == 7) chk("full on 8th write", 32'(full), 32'd1);
      if (i == 9) chk("first drained byte", 32'(rdata), 32'd1);
      if (i == 16) chk("last drained byte", 32'(rdata), 32'd8);
    end
    chk("write+pop empty rdata", 32'(rdata), 32'h77);

    apply("clr", 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) apply("fill", 1, 0, 0, 8'(8'h80 + i));
    apply("full w+r", 1, 1, 0, 8'h88);
    chk("full w+r wrcnt", 32'(wrcnt), 32'd8);
    chk("full w+r overflow", 32'(overflow), 32'd0);
    chk("full w+r rdata oldest", 32'(rdata), 32'h80);

    apply("clr", 0, 0, 1, 8'h00);
    apply("empty pop", 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) apply("pre-flush w", 1, 0, 0, 8'(8'hC0 + i));
    apply("flush w/ wr", 1, 1, 1, 8'hEE);
    chk("flush wrcnt", 32'(wrcnt), 32'd0);
    chk("flush underflow", 32'(underflow), 32'd0);
    for (int i = 0; i < 20; i++) apply("stream", 1, i > 0 && i % 3 != 0, 0, 8'(8'h40 + i));
    while (q.size() != 0) apply("stream drain", 0, 1, 0, 8'h00);
    chk("stream last byte", 32'(rdata), 32'h53);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
